aes_enc_sched: RTL

- Round-robin scheduler that shares one on-the-fly AES encipher core among NUM_REQ requesters, such as per-bearer 5G ciphering channels.
- Decides whether a key (re)load is needed, sequences the core's init and next commands, and returns each result to the requester that owns it.
- One transaction is in flight at a time.
- Sits between the requester fabric and the encipher core plus its key store/expander.

---
 rtl/aes_sched_pkg.sv | 20 ++
 rtl/aes_rr_arbiter.sv | 31 +++
 rtl/aes_enc_sched.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES encipher-core scheduler.
package aes_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_KEY_INIT,
        ST_KEY_WAIT,
        ST_START,
        ST_BUSY,
        ST_DONE,
        ST_RESP
    } sched_state_t;

    localparam logic AES_128_BIT_KEY = 1'b0;
    localparam logic AES_256_BIT_KEY = 1'b1;

    localparam int unsigned WAIT_CNT_W = 10;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module aes_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    // Scan from the farthest offset down so the closest request to ptr wins.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
            idx = 32'(ptr) + 32'(off);
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[IDX_W'(idx)]) begin
                grant                = '0;
                grant[IDX_W'(idx)]   = 1'b1;
                grant_idx            = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/aes_enc_sched.sv
// Shares one AES encipher core among NUM_REQ requesters; one transaction in flight,
// key reload only when the granted key slot or length differs from the loaded one.
module aes_enc_sched
    import aes_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned KEY_ID_W = 4,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [128*NUM_REQ-1:0]    req_block,
    input  logic [KEY_ID_W*NUM_REQ-1:0] req_key_id,
    input  logic [NUM_REQ-1:0]        req_keylen,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [127:0]              rsp_block,
    output logic                      rsp_err,
    input  logic                      key_invalidate,
    output logic                      core_init,
    output logic                      core_next,
    output logic                      core_keylen,
    output logic [KEY_ID_W-1:0]       core_key_id,
    output logic [127:0]              core_block,
    input  logic                      core_ready,
    input  logic [127:0]              core_result,
    input  logic                      key_ready
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BLK_W = 128;

    sched_state_t          state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic                  loaded_valid_q, loaded_valid_d;
    logic [KEY_ID_W-1:0]   loaded_key_id_q, loaded_key_id_d;
    logic                  loaded_keylen_q, loaded_keylen_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  key_low_seen_q, key_low_seen_d;

    logic [NUM_REQ-1:0]    req_ready_d, rsp_valid_d;
    logic [127:0]          rsp_block_d, core_block_d;
    logic                  rsp_err_d, core_init_d, core_next_d, core_keylen_d;
    logic [KEY_ID_W-1:0]   core_key_id_d;

    logic [NUM_REQ-1:0]    gnt_oh_c;
    logic [IDX_W-1:0]      gnt_idx_c;
    logic                  timed_out_c;

    aes_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (gnt_oh_c),
        .grant_idx (gnt_idx_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        owner_d         = owner_q;
        loaded_valid_d  = loaded_valid_q;
        loaded_key_id_d = loaded_key_id_q;
        loaded_keylen_d = loaded_keylen_q;
        wait_cnt_d      = wait_cnt_q + 1'b1;
        key_low_seen_d  = key_low_seen_q;
        req_ready_d     = '0;
        rsp_valid_d     = '0;
        rsp_block_d     = rsp_block;
        rsp_err_d       = rsp_err;
        core_init_d     = 1'b0;
        core_next_d     = 1'b0;
        core_keylen_d   = core_keylen;
        core_key_id_d   = core_key_id;
        core_block_d    = core_block;
        timed_out_c     = (wait_cnt_q == WAIT_CNT_W'(TIMEOUT));

        case (state_q)
            ST_IDLE: begin
                if ((|req_valid) && core_ready) begin
                    state_d       = ST_GRANT;
                    req_ready_d   = gnt_oh_c;
                    owner_d       = gnt_idx_c;
                    core_block_d  = req_block[32'(gnt_idx_c) * BLK_W +: BLK_W];
                    core_key_id_d = req_key_id[32'(gnt_idx_c) * KEY_ID_W +: KEY_ID_W];
                    core_keylen_d = req_keylen[gnt_idx_c];
                    rr_ptr_d      = (gnt_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_c + 1'b1;
                end
            end
            ST_GRANT: begin
                if (!loaded_valid_q || key_invalidate ||
                    (core_key_id != loaded_key_id_q) || (core_keylen != loaded_keylen_q)) begin
                    state_d = ST_KEY_INIT;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_KEY_INIT: begin
                core_init_d     = 1'b1;
                loaded_key_id_d = core_key_id;
                loaded_keylen_d = core_keylen;
                loaded_valid_d  = 1'b1;
                key_low_seen_d  = 1'b0;
                state_d         = ST_KEY_WAIT;
            end
            ST_KEY_WAIT: begin
                if (timed_out_c) begin
                    state_d        = ST_RESP;
                    rsp_err_d      = 1'b1;
                    rsp_block_d    = '0;
                    loaded_valid_d = 1'b0;
                end else if (!key_low_seen_q) begin
                    if (!key_ready) begin
                        key_low_seen_d = 1'b1;
                        wait_cnt_d     = '0;
                    end
                end else if (key_ready) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                core_next_d = 1'b1;
                state_d     = ST_BUSY;
            end
            ST_BUSY: begin
                if (timed_out_c) begin
                    state_d        = ST_RESP;
                    rsp_err_d      = 1'b1;
                    rsp_block_d    = '0;
                    loaded_valid_d = 1'b0;
                end else if (!core_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (timed_out_c) begin
                    state_d        = ST_RESP;
                    rsp_err_d      = 1'b1;
                    rsp_block_d    = '0;
                    loaded_valid_d = 1'b0;
                end else if (core_ready) begin
                    state_d     = ST_RESP;
                    rsp_err_d   = 1'b0;
                    rsp_block_d = core_result;
                end
            end
            ST_RESP: begin
                // rsp_valid only carries the owner bit, so other rsp_ready bits drop out.
                if (|(rsp_valid & rsp_ready)) begin
                    state_d   = ST_IDLE;
                    rsp_err_d = 1'b0;
                end else begin
                    rsp_valid_d = NUM_REQ'(1) << owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (key_invalidate) begin
            loaded_valid_d = 1'b0;
        end
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            rr_ptr_q        <= '0;
            owner_q         <= '0;
            loaded_valid_q  <= 1'b0;
            loaded_key_id_q <= '0;
            loaded_keylen_q <= AES_128_BIT_KEY;
            wait_cnt_q      <= '0;
            key_low_seen_q  <= 1'b0;
            req_ready       <= '0;
            rsp_valid       <= '0;
            rsp_block       <= '0;
            rsp_err         <= 1'b0;
            core_init       <= 1'b0;
            core_next       <= 1'b0;
            core_keylen     <= AES_128_BIT_KEY;
            core_key_id     <= '0;
            core_block      <= '0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            owner_q         <= owner_d;
            loaded_valid_q  <= loaded_valid_d;
            loaded_key_id_q <= loaded_key_id_d;
            loaded_keylen_q <= loaded_keylen_d;
            wait_cnt_q      <= wait_cnt_d;
            key_low_seen_q  <= key_low_seen_d;
            req_ready       <= req_ready_d;
            rsp_valid       <= rsp_valid_d;
            rsp_block       <= rsp_block_d;
            rsp_err         <= rsp_err_d;
            core_init       <= core_init_d;
            core_next       <= core_next_d;
            core_keylen     <= core_keylen_d;
            core_key_id     <= core_key_id_d;
            core_block      <= core_block_d;
        end
    end

endmodule
